// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data memory. Port A is the
// core, port B is the host. One access is performed per grant cycle; the
// memory is combinational on read and writes on the clock edge that ends
// the grant cycle. Ties go to the port that was not granted most recently.
//
// Build option:
//   DMEM_ARB_LOCK_EN  when defined, the host may hold b_lock to keep the
//                     memory across several back-to-back accesses (LOCK_B).
//                     When undefined, b_lock is ignored and LOCK_B is never
//                     entered.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset)
//   a_req      core request, held with a_we/a_addr/a_wdata until a_gnt
//   a_we       core write enable (1 = write, 0 = read)
//   a_addr     core word address
//   a_wdata    core write data
//   a_gnt      core access performed this cycle
//   a_rdata    core read data, mem_rdata while a_gnt=1, else 0
//   b_req      host request (same rules as port A)
//   b_we       host write enable
//   b_addr     host word address
//   b_wdata    host write data
//   b_lock     host burst-lock request
//   b_gnt      host access performed this cycle
//   b_rdata    host read data, mem_rdata while b_gnt=1, else 0
//   mem_write  data-memory write strobe
//   mem_addr   data-memory address
//   mem_wdata  data-memory write data
//   mem_rdata  data-memory combinational read data
//   last_b     round-robin pointer, 1 = B granted most recently
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dmem_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_req,
    input  logic       a_we,
    input  logic [5:0] a_addr,
    input  logic [7:0] a_wdata,
    output logic       a_gnt,
    output logic [7:0] a_rdata,
    input  logic       b_req,
    input  logic       b_we,
    input  logic [5:0] b_addr,
    input  logic [7:0] b_wdata,
    input  logic       b_lock,
    output logic       b_gnt,
    output logic [7:0] b_rdata,
    output logic       mem_write,
    output logic [5:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic       last_b
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_A = 2'd1;
    localparam logic [1:0] SERVE_B = 2'd2;
    localparam logic [1:0] LOCK_B  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       last_b_q;
    logic       last_b_next;

    // Requests with the currently served port removed. A port's request is
    // still asserted during its own grant cycle (it is held until a_gnt /
    // b_gnt), so without this mask it would be counted again and could win
    // a second, spurious access.
    logic       a_req_masked;
    logic       b_req_masked;

    // Grant qualifiers before the reset gate.
    logic       a_sel;
    logic       b_sel;

`ifndef DMEM_ARB_LOCK_EN
    // Lock input has no function in this build.
    logic       unused_b_lock;
    assign unused_b_lock = b_lock;
`endif

    // -------------------------------------------------------------------------
    // Request masking
    // -------------------------------------------------------------------------
    assign a_req_masked = a_req && (state != SERVE_A);
    assign b_req_masked = b_req && (state != SERVE_B);

    // -------------------------------------------------------------------------
    // Next-state and round-robin pointer
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_next  = IDLE;
        last_b_next = last_b_q;

        // Pointer follows the state being left, whatever comes next.
        case (state)
            SERVE_A: last_b_next = 1'b0;
            SERVE_B: last_b_next = 1'b1;
            LOCK_B:  last_b_next = 1'b1;
            default: last_b_next = last_b_q;
        endcase

        // Round-robin choice on the masked requests. A true tie can only
        // occur from IDLE, because a SERVE state always masks its own port.
        if (a_req_masked && b_req_masked) begin
            state_next = last_b_q ? SERVE_A : SERVE_B;
        end else if (a_req_masked) begin
            state_next = SERVE_A;
        end else if (b_req_masked) begin
            state_next = SERVE_B;
        end else begin
            state_next = IDLE;
        end

`ifdef DMEM_ARB_LOCK_EN
        // Host holding the lock keeps the memory after its SERVE_B cycle;
        // port A is locked out until b_lock drops.
        if (state == SERVE_B && b_lock) begin
            state_next = LOCK_B;
        end
        if (state == LOCK_B) begin
            state_next = b_lock ? LOCK_B : IDLE;
        end
`else
        // Unreachable in this build; recover to IDLE should it ever appear.
        if (state == LOCK_B) begin
            state_next = IDLE;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // last_b resets to 1 so that port A wins the first tie after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_b_q <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples values from before this edge.
            state    <= state_next;
            last_b_q <= last_b_next;
        end
    end

    // -------------------------------------------------------------------------
    // Grants
    // -------------------------------------------------------------------------
    // A grant also requires the request to still be present: a requester
    // that withdrew after arbitration gets neither a grant nor a memory
    // access. The reset term forces everything quiet combinationally while
    // reset is low, independent of the clock, which also aborts an access
    // that is in flight when reset arrives.
    assign a_sel = (state == SERVE_A) && a_req;
    assign b_sel = ((state == SERVE_B) || (state == LOCK_B)) && b_req;

    assign a_gnt = reset && a_sel;
    assign b_gnt = reset && b_sel;

    // -------------------------------------------------------------------------
    // Memory-side mux
    // -------------------------------------------------------------------------
    // Memory lines are driven only by a granted port; in every other cycle
    // (IDLE, withdrawn request, reset) they are held at zero so no write can
    // ever occur without a grant.
    always_comb begin
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_write = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_write = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read data return
    // -------------------------------------------------------------------------
    assign a_rdata = a_gnt ? mem_rdata : 8'h00;
    assign b_rdata = b_gnt ? mem_rdata : 8'h00;

    // Pointer reads as 1 for the whole reset period.
    assign last_b = reset ? last_b_q : 1'b1;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have ports (clock and reset first):
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- a_req  input  1  core request; held with a_we/a_addr/a_wdata until a_gnt
- a_we  input  1  core write enable (1 = write, 0 = read)
- a_addr  input  6  core word address
- a_wdata  input  8  core write data
- a_gnt  output  1  core access performed this cycle
- a_rdata  output  8  core read data, valid while a_gnt=1 and a_we=0
- b_req / b_we / b_addr / b_wdata  input  1/1/6/8  host port, same rules as port A
- b_lock  input  1  host burst-lock request
- b_gnt / b_rdata  output  1/8  host grant and read data
- mem_write  output  1  data-memory write strobe
- mem_addr  output  6  data-memory address
- mem_wdata  output  8  data-memory write data
- mem_rdata  input  8  data-memory combinational read data
- last_b  output  1  round-robin pointer, 1 = B granted most recently

Function
REQ-002 SHALL implement a registered FSM with states IDLE, SERVE_A, SERVE_B, LOCK_B.
REQ-003 SHALL raise a_gnt only in SERVE_A and b_gnt only in SERVE_B or LOCK_B, each for exactly one cycle per transaction.
REQ-004 SHALL choose the next state at every edge from IDLE, SERVE_A or SERVE_B using masked requests; the granted port's own request is masked in its SERVE cycle.
REQ-005 Arbitration: only A requests -> SERVE_A; only B -> SERVE_B; both -> the port not granted last (last_b=1 -> SERVE_A, else SERVE_B); neither -> IDLE.
REQ-006 SHALL update last_b to 0 when leaving SERVE_A and to 1 when leaving SERVE_B or LOCK_B.
REQ-007 Latency: a request present at edge N with no competition SHALL be granted in the cycle after edge N (one cycle). Sustained dual requests SHALL alternate A,B,A,B with no idle cycle.
REQ-008 In a SERVE cycle, the arbiter SHALL drive the winning port's address and write data onto mem_addr and mem_wdata, and SHALL drive mem_write = winner_we.
REQ-009 In IDLE, the arbiter SHALL drive mem_write=0 and mem_addr=0 and mem_wdata=0.
REQ-010 SHALL drive a_rdata and b_rdata from mem_rdata while the corresponding grant is high, and 0 otherwise.
REQ-011 A requester dropping req before its grant SHALL be ignored; no grant or memory access SHALL be produced for it.
REQ-012 A read and a write on the same address in consecutive grants SHALL be serialised: the write issued in cycle N is visible to a read in cycle N+1.
REQ-013 The arbiter SHALL never assert a_gnt and b_gnt in the same cycle, and SHALL never assert mem_write without a grant.

Reset
REQ-014 While reset=0, the arbiter SHALL set state=IDLE and last_b=1 (A wins the first tie), and SHALL force a_gnt, b_gnt and mem_write to 0 and all data and address outputs to 0, regardless of clk.
REQ-015 Reset asserted mid-transaction SHALL abort it with no memory write; after release, the FSM SHALL re-arbitrate from IDLE on the first edge.

Configuration
REQ-016 Macro DMEM_ARB_LOCK_EN SHALL enable burst locking.
- With the macro: SERVE_B with b_lock=1 SHALL go to LOCK_B.
- In LOCK_B: b_gnt = b_req combinationally, the memory is driven by B, and A is blocked.
- LOCK_B SHALL exit to IDLE at the first edge with b_lock=0.
REQ-017 Without DMEM_ARB_LOCK_EN, the arbiter SHALL ignore b_lock, LOCK_B SHALL be unreachable, and behaviour SHALL follow REQ-002..REQ-015 only.

Verification
REQ-018 Reset state: with reset=0 and a_req=b_req=1 -> a_gnt=b_gnt=mem_write=0 and last_b=1; after reset rises -> a_gnt in the first SERVE cycle.
REQ-019 Single write then read:
- Stimulus: a_req, a_we=1, a_addr=5, a_wdata=8'h3C, followed by a_req, a_we=0, a_addr=5.
- Response: mem_write=1 at addr 5 in the grant cycle, then a_rdata=8'h3C with a_gnt=1.
REQ-020 Contention: a_req=b_req=1 held for 8 cycles with each requester re-requesting after every grant -> grant order A,B,A,B, with exactly 4 a_gnt and 4 b_gnt.
REQ-021 Withdrawal: b_req pulsed for one cycle while a SERVE_A is in progress and dropped before grant -> no b_gnt and no mem_write for addr b_addr.
REQ-022 Lock (DMEM_ARB_LOCK_EN): b_lock=1 with 3 back-to-back host writes to addr 0..2 and a_req=1 -> 3 consecutive b_gnt and no a_gnt; then b_lock=0 -> a_gnt within 2 cycles.
REQ-023 Mid-operation reset: reset=0 during SERVE_B with b_we=1 -> no mem_write; after release, state=IDLE and last_b=1.
